pcm_slot_sched: RTL and testbench

- Programmable PCM frame-sync scheduler for the codec highway; replaces fixed per-channel sync decoding.
- Counts bit ticks into slots and frames, and drives one frame-sync per codec channel at a CPU-configured timeslot.
- Configuration is double-buffered: CPU writes shadow registers, and the commit applies them only at a frame boundary, so syncs never glitch mid-frame.
- Sits between the CPU bus decode and the codec FS pins, clocked from the CPLD master clock with a bit-rate enable.

---
 rtl/pcm_slot_sched_if.sv | 20 ++
 rtl/pcm_slot_sched.sv | 114 +++++++++++
 tb/tb_pcm_slot_sched.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pcm_slot_sched_if.sv
// CPU-side configuration bus of the PCM slot scheduler: shadow write/read and commit handshake.
interface pcm_slot_sched_if;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       cfg_re;
  logic [7:0] cfg_rdata;
  logic       cfg_commit;
  logic       cfg_pending;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, cfg_re, cfg_commit,
    input  cfg_rdata, cfg_pending
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, cfg_re, cfg_commit,
    output cfg_rdata, cfg_pending
  );
endinterface

// File: rtl/pcm_slot_sched.sv
// PCM frame-sync scheduler: counts bit ticks into slots/frames and raises one fsr per channel in its slot.
// Outputs update on bclk_en from the new count; shadow config moves to active only at a frame start.
module pcm_slot_sched #(
  parameter int NCH       = 8,
  parameter int NSLOT     = 32,
  parameter int SLOT_BITS = 8
) (
  input  logic                clk,
  input  logic                rest,
  input  logic                bclk_en,
  pcm_slot_sched_if.slave     cfg,
  output logic                coll,
  output logic                frame,
  output logic [NCH-1:0]      fsr,
  output logic [6:0]          slot_cnt
);

  localparam int BW = $clog2(SLOT_BITS);

  logic [BW-1:0]         bit_cnt;
  logic [BW-1:0]         bit_nxt;
  logic [6:0]            slot_nxt;
  logic                  fstart;
  logic                  xfer;
  logic                  hit;
  logic                  coll_nxt;
  logic [7:0]            rd_nxt;
  logic [NCH-1:0]        sh_en, act_en, eff_en, fsr_nxt;
  logic [NCH-1:0][6:0]   sh_slot, act_slot, eff_slot;

  always_comb begin
    bit_nxt  = (bit_cnt == BW'(SLOT_BITS - 1)) ? '0 : bit_cnt + BW'(1);
    slot_nxt = slot_cnt;
    if (bit_cnt == BW'(SLOT_BITS - 1))
      slot_nxt = (slot_cnt == 7'(NSLOT - 1)) ? 7'd0 : slot_cnt + 7'd1;
  end

  assign fstart = bclk_en && (bit_nxt == '0) && (slot_nxt == 7'd0);
  // The frame-start tick that performs the transfer already schedules from the shadow copy.
  assign xfer     = fstart && cfg.cfg_pending;
  assign eff_en   = xfer ? sh_en   : act_en;
  assign eff_slot = xfer ? sh_slot : act_slot;

  // Lowest enabled index wins its slot; out-of-range slots never equal slot_nxt.
  always_comb begin
    fsr_nxt = '0;
    hit     = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!hit && eff_en[i] && (eff_slot[i] == slot_nxt)) begin
        fsr_nxt[i] = 1'b1;
        hit        = 1'b1;
      end
    end
  end

  always_comb begin
    coll_nxt = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      for (int j = i + 1; j < NCH; j++) begin
        if (act_en[i] && act_en[j] && (act_slot[i] == act_slot[j]) &&
            ({1'b0, act_slot[i]} < 8'(NSLOT)))
          coll_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    rd_nxt = 8'd0;
    for (int i = 0; i < NCH; i++)
      if (cfg.cfg_addr == 4'(i)) rd_nxt = {sh_en[i], sh_slot[i]};
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      bit_cnt         <= BW'(SLOT_BITS - 1);
      slot_cnt        <= 7'(NSLOT - 1);
      fsr             <= '0;
      frame           <= 1'b1;
      coll            <= 1'b0;
      cfg.cfg_rdata   <= 8'd0;
      cfg.cfg_pending <= 1'b0;
      sh_en           <= '0;
      sh_slot         <= '0;
      act_en          <= '0;
      act_slot        <= '0;
    end else begin
      if (bclk_en) begin
        bit_cnt  <= bit_nxt;
        slot_cnt <= slot_nxt;
        fsr      <= fsr_nxt;
        frame    <= !((bit_nxt == '0) && (slot_nxt == 7'd0));
      end
      if (xfer) begin
        act_en   <= sh_en;
        act_slot <= sh_slot;
      end
      // A commit landing on a frame-start tick without a prior pending waits a full frame.
      if (xfer)
        cfg.cfg_pending <= 1'b0;
      else if (cfg.cfg_commit)
        cfg.cfg_pending <= 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (cfg.cfg_we && (cfg.cfg_addr == 4'(i))) begin
          sh_en[i]   <= cfg.cfg_wdata[7];
          sh_slot[i] <= cfg.cfg_wdata[6:0];
        end
      end
      if (cfg.cfg_re)
        cfg.cfg_rdata <= rd_nxt;
      coll <= coll_nxt;
    end
  end

endmodule

// File: tb/tb_pcm_slot_sched.sv
// Directed bench for pcm_slot_sched with a tick-level reference model feeding an expectation queue.
module tb_pcm_slot_sched;
  localparam int NCH   = 8;
  localparam int NSLOT = 32;
  localparam int SB    = 8;
  localparam int FR    = NSLOT * SB;

  logic           clk = 1'b0;
  logic           rest;
  logic           bclk_en;
  logic           coll;
  logic           frame;
  logic [NCH-1:0] fsr;
  logic [6:0]     slot_cnt;

  pcm_slot_sched_if cif ();

  pcm_slot_sched #(.NCH(NCH), .NSLOT(NSLOT), .SLOT_BITS(SB)) dut (
    .clk      (clk),
    .rest     (rest),
    .bclk_en  (bclk_en),
    .cfg      (cif),
    .coll     (coll),
    .frame    (frame),
    .fsr      (fsr),
    .slot_cnt (slot_cnt)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  int             t;
  logic           m_pend;
  logic [NCH-1:0] m_en, m_sh_en;
  logic [6:0]     m_slot [NCH];
  logic [6:0]     m_sh_slot [NCH];

  function automatic logic [31:0] pack(input logic p, input logic fr,
                                       input logic [6:0] sl, input logic [NCH-1:0] fs);
    return {15'd0, p, fr, sl, fs};
  endfunction

  function automatic logic [7:0] sh_val(input int a);
    if (a < NCH) return {m_sh_en[a], m_sh_slot[a]};
    return 8'd0;
  endfunction

  function automatic logic model_coll();
    int cnt [NSLOT];
    for (int s = 0; s < NSLOT; s++) cnt[s] = 0;
    for (int i = 0; i < NCH; i++) begin
      if (m_en[i] && int'(m_slot[i]) < NSLOT) begin
        cnt[m_slot[i]]++;
        if (cnt[m_slot[i]] > 1) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed=%h but no expectation queued", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic model_reset();
    t      = FR - 1;
    m_pend = 1'b0;
    m_en   = '0;
    m_sh_en = '0;
    for (int i = 0; i < NCH; i++) begin
      m_slot[i]    = 7'd0;
      m_sh_slot[i] = 7'd0;
    end
  endtask

  // One bit tick (bclk_en for one clk, then one idle clk); optional commit on the tick clk.
  task automatic tick(input bit commit);
    logic [NCH-1:0] f;
    bit             hit;
    int             s;
    bclk_en        = 1'b1;
    cif.cfg_commit = commit;
    t = (t == FR - 1) ? 0 : t + 1;
    if (t == 0 && m_pend) begin
      m_en   = m_sh_en;
      m_slot = m_sh_slot;
      m_pend = 1'b0;
    end else if (commit) begin
      m_pend = 1'b1;
    end
    s   = t / SB;
    f   = '0;
    hit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!hit && m_en[i] && int'(m_slot[i]) == s) begin
        f[i] = 1'b1;
        hit  = 1'b1;
      end
    end
    exp_q.push_back(pack(m_pend, t != 0, 7'(s), f));
    @(negedge clk);
    bclk_en        = 1'b0;
    cif.cfg_commit = 1'b0;
    check($sformatf("tick%0d", t), pack(cif.cfg_pending, frame, slot_cnt, fsr));
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b0);
  endtask

  task automatic run_to(input int target);
    do tick(1'b0); while (t != target);
  endtask

  task automatic write_cfg(input logic [3:0] a, input logic [7:0] d);
    cif.cfg_we    = 1'b1;
    cif.cfg_addr  = a;
    cif.cfg_wdata = d;
    if (int'(a) < NCH) begin
      m_sh_en[a]   = d[7];
      m_sh_slot[a] = d[6:0];
    end
    @(negedge clk);
    cif.cfg_we = 1'b0;
  endtask

  task automatic read_cfg(input logic [3:0] a, input string tag);
    cif.cfg_re   = 1'b1;
    cif.cfg_addr = a;
    exp_q.push_back(32'(sh_val(int'(a))));
    @(negedge clk);
    cif.cfg_re = 1'b0;
    check(tag, 32'(cif.cfg_rdata));
  endtask

  task automatic rw_same(input logic [3:0] a, input logic [7:0] d);
    cif.cfg_re = 1'b1;
    exp_q.push_back(32'(sh_val(int'(a))));
    write_cfg(a, d);
    cif.cfg_re = 1'b0;
    check("rw_same_old", 32'(cif.cfg_rdata));
  endtask

  task automatic commit_now();
    cif.cfg_commit = 1'b1;
    m_pend = 1'b1;
    exp_q.push_back(32'(m_pend));
    @(negedge clk);
    cif.cfg_commit = 1'b0;
    check("pending_set", 32'(cif.cfg_pending));
  endtask

  task automatic check_coll(input string tag);
    exp_q.push_back(32'(model_coll()));
    check(tag, 32'(coll));
  endtask

  task automatic do_reset(input string tag);
    rest = 1'b1;
    model_reset();
    @(negedge clk);
    exp_q.push_back(pack(1'b0, 1'b1, 7'(NSLOT - 1), '0));
    check({tag, "_outputs"}, pack(cif.cfg_pending, frame, slot_cnt, fsr));
    exp_q.push_back(32'd0);
    check({tag, "_rdata"}, 32'(cif.cfg_rdata));
    exp_q.push_back(32'd0);
    check({tag, "_coll"}, 32'(coll));
    rest = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bclk_en        = 1'b0;
    cif.cfg_we     = 1'b0;
    cif.cfg_re     = 1'b0;
    cif.cfg_commit = 1'b0;
    cif.cfg_addr   = 4'd0;
    cif.cfg_wdata  = 8'd0;
    rest           = 1'b1;
    @(negedge clk);
    do_reset("reset");

    // Idle frame: frame marker on the first tick and every FR ticks, no syncs.
    run(FR + 1);
    run_to(FR - 1);

    // Basic placement, including the last slot and a repeated commit.
    write_cfg(4'd0, 8'h80);
    write_cfg(4'd1, 8'h81);
    write_cfg(4'd7, 8'h9F);
    commit_now();
    commit_now();
    run(2 * FR);

    // Mid-frame rewrite: current frame keeps slot 0, slot 5 from the next frame.
    run_to(80);
    write_cfg(4'd0, 8'h85);
    commit_now();
    run_to(FR - 1);
    run(FR);

    // Commit coinciding with the frame-start tick is deferred by a full frame.
    write_cfg(4'd3, 8'h8A);
    tick(1'b1);
    run_to(FR - 1);
    run(FR);

    // Collision: lowest index wins; out-of-range slot stays silent.
    write_cfg(4'd2, 8'h83);
    write_cfg(4'd4, 8'h83);
    write_cfg(4'd5, 8'hA8);
    commit_now();
    run(FR);
    check_coll("coll_set");
    write_cfg(4'd4, 8'h84);
    commit_now();
    run(FR);
    check_coll("coll_clear");

    // Readback, same-cycle read/write and out-of-range addresses.
    read_cfg(4'd7, "read_ch7");
    rw_same(4'd6, 8'h86);
    read_cfg(4'd6, "read_ch6_new");
    write_cfg(4'd9, 8'hFF);
    read_cfg(4'd9, "read_oob");

    // Reset mid-slot while fsr[1] is high with a commit pending.
    run_to(10);
    commit_now();
    read_cfg(4'd1, "read_ch1");
    do_reset("midreset");
    read_cfg(4'd1, "read_ch1_after_reset");
    run(3);
    check_coll("coll_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
